gpio_arb: RTL and testbench

GPIO_ARB -- requirements
Module: gpio_arb

---
 rtl/gpio_arb_pkg.sv | 14 +
 rtl/gpio_arb_if.sv | 39 +++
 rtl/gpio_arb_rr_arb2.sv | 21 ++
 rtl/gpio_arb.sv | 118 +++++++++++
 tb/tb_gpio_arb.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-master GPIO arbiter.
// The FSM state encoding and the master index values live here.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/gpio_arb_if.sv
// Bus bundle between two Avalon masters, the arbiter and the shared GPIO slave.
// slave: the arbiter's view; master: the environment's view.
interface gpio_arb_if #(
   parameter int DATA_W = 32
);
   logic              m0_write;
   logic              m1_write;
   logic              m0_read;
   logic              m1_read;
   logic [DATA_W-1:0] m0_writedata;
   logic [DATA_W-1:0] m1_writedata;
   logic [DATA_W-1:0] m0_readdata;
   logic [DATA_W-1:0] m1_readdata;
   logic              m0_waitrequest;
   logic              m1_waitrequest;
   logic              m0_readdatavalid;
   logic              m1_readdatavalid;
   logic              avalon_write;
   logic              avalon_read;
   logic [DATA_W-1:0] avalon_writedata;
   logic [DATA_W-1:0] avalon_readdata;

   modport slave (
      input  m0_write, m1_write, m0_read, m1_read,
      input  m0_writedata, m1_writedata, avalon_readdata,
      output m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
      output m0_readdatavalid, m1_readdatavalid,
      output avalon_write, avalon_read, avalon_writedata
   );

   modport master (
      output m0_write, m1_write, m0_read, m1_read,
      output m0_writedata, m1_writedata, avalon_readdata,
      input  m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
      input  m0_readdatavalid, m1_readdatavalid,
      input  avalon_write, avalon_read, avalon_writedata
   );

endinterface

// File: rtl/gpio_arb_rr_arb2.sv
// Combinational two-input round-robin picker.
// On a tie the master that did not win last time is chosen.
module rr_arb2
   import gpio_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   always_comb begin
      grant = M0;
      case (req)
         2'b11:   grant = ~last;
         2'b10:   grant = M1;
         2'b01:   grant = M0;
         default: grant = M0;
      endcase
   end

endmodule

// File: rtl/gpio_arb.sv
// Round-robin arbiter giving two Avalon masters single-transfer access to one GPIO slave.
// IDLE picks a master, ISSUE forwards one strobe, RDWAIT returns the read data.
module gpio_arb
   import gpio_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic       clk,
   input logic       reset,
   gpio_arb_if.slave bus
);

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic [1:0]        req_s;
   logic              pick_s;
   logic              g_wr_s, g_rd_s;
   logic [DATA_W-1:0] g_wd_s;

   logic              wait0_s, wait1_s, rdv0_s, rdv1_s, avw_s, avr_s;
   logic [DATA_W-1:0] rd0_s, rd1_s, avwd_s;

   assign req_s  = {bus.m1_write | bus.m1_read, bus.m0_write | bus.m0_read};
   assign g_wr_s = (grant_q == M1) ? bus.m1_write     : bus.m0_write;
   assign g_rd_s = (grant_q == M1) ? bus.m1_read      : bus.m0_read;
   assign g_wd_s = (grant_q == M1) ? bus.m1_writedata : bus.m0_writedata;

   rr_arb2 u_rr_arb2 (
      .req   (req_s),
      .last  (last_q),
      .grant (pick_s)
   );

   // State, grant and last-grant registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= M0;
         last_q  <= M1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Next-state and output decode; reset forces outputs idle in the same cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wait0_s = 1'b1;
      wait1_s = 1'b1;
      rdv0_s  = 1'b0;
      rdv1_s  = 1'b0;
      rd0_s   = {DATA_W{1'b0}};
      rd1_s   = {DATA_W{1'b0}};
      avw_s   = 1'b0;
      avr_s   = 1'b0;
      avwd_s  = {DATA_W{1'b0}};
      if (reset) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_s) begin
                  grant_d = pick_s;
                  last_d  = pick_s;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
            ISSUE: begin
               if (grant_q == M1) begin
                  wait1_s = 1'b0;
               end else begin
                  wait0_s = 1'b0;
               end
               // Write wins over a simultaneous read; a dropped request aborts.
               if (g_wr_s) begin
                  avw_s   = 1'b1;
                  avwd_s  = g_wd_s;
                  state_d = IDLE;
               end else if (g_rd_s) begin
                  avr_s   = 1'b1;
                  state_d = RDWAIT;
               end else begin
                  state_d = IDLE;
               end
            end
            RDWAIT: begin
               if (grant_q == M1) begin
                  rdv1_s = 1'b1;
                  rd1_s  = bus.avalon_readdata;
               end else begin
                  rdv0_s = 1'b1;
                  rd0_s  = bus.avalon_readdata;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.m0_waitrequest   = wait0_s;
   assign bus.m1_waitrequest   = wait1_s;
   assign bus.m0_readdatavalid = rdv0_s;
   assign bus.m1_readdatavalid = rdv1_s;
   assign bus.m0_readdata      = rd0_s;
   assign bus.m1_readdata      = rd1_s;
   assign bus.avalon_write     = avw_s;
   assign bus.avalon_read      = avr_s;
   assign bus.avalon_writedata = avwd_s;

endmodule

// File: tb/tb_gpio_arb.sv
// Self-checking bench for gpio_arb: directed scenarios then random traffic,
// every cycle compared against a transfer-level reference model.
module tb_gpio_arb;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gpio_arb_if #(.DATA_W(DW)) bus ();

   gpio_arb #(.DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: cycles into the current transfer (0 none, 1 issue, 2 data return).
   int   age = 0;
   logic owner = 1'b0;
   logic last_w = 1'b1;

   logic          s_wait0, s_wait1, s_rdv0, s_rdv1, s_avw, s_avr;
   logic [DW-1:0] s_rd0, s_rd1, s_avwd;
   int            n_avw, n_avr, n_rdv;
   int            grant_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w0, input logic r0, input logic [DW-1:0] wd0,
                        input logic w1, input logic r1, input logic [DW-1:0] wd1);
      bus.m0_write = w0; bus.m0_read = r0; bus.m0_writedata = wd0;
      bus.m1_write = w1; bus.m1_read = r1; bus.m1_writedata = wd1;
   endtask

   task automatic cycle();
      logic          w, r, e_wait0, e_wait1, e_rdv0, e_rdv1, e_avw, e_avr;
      logic [DW-1:0] e_rd0, e_rd1, e_avwd;
      logic [1:0]    req;
      @(negedge clk);
      s_wait0 = bus.m0_waitrequest;   s_wait1 = bus.m1_waitrequest;
      s_rdv0  = bus.m0_readdatavalid; s_rdv1  = bus.m1_readdatavalid;
      s_rd0   = bus.m0_readdata;      s_rd1   = bus.m1_readdata;
      s_avw   = bus.avalon_write;     s_avr   = bus.avalon_read;
      s_avwd  = bus.avalon_writedata;
      e_wait0 = 1'b1; e_wait1 = 1'b1; e_rdv0 = 1'b0; e_rdv1 = 1'b0;
      e_rd0 = '0; e_rd1 = '0; e_avw = 1'b0; e_avr = 1'b0; e_avwd = '0;
      w = owner ? bus.m1_write : bus.m0_write;
      r = owner ? bus.m1_read  : bus.m0_read;
      if (!reset && age == 1) begin
         if (owner) e_wait1 = 1'b0; else e_wait0 = 1'b0;
         e_avw  = w;
         e_avr  = !w && r;
         e_avwd = w ? (owner ? bus.m1_writedata : bus.m0_writedata) : '0;
         if (w || r) grant_log.push_back(int'(owner));
      end else if (!reset && age == 2) begin
         if (owner) begin e_rdv1 = 1'b1; e_rd1 = bus.avalon_readdata; end
         else       begin e_rdv0 = 1'b1; e_rd0 = bus.avalon_readdata; end
      end
      chk("m0_waitrequest", s_wait0, e_wait0);
      chk("m1_waitrequest", s_wait1, e_wait1);
      chk("m0_readdatavalid", s_rdv0, e_rdv0);
      chk("m1_readdatavalid", s_rdv1, e_rdv1);
      chk("m0_readdata", s_rd0, e_rd0);
      chk("m1_readdata", s_rd1, e_rd1);
      chk("avalon_write", s_avw, e_avw);
      chk("avalon_read", s_avr, e_avr);
      chk("avalon_writedata", s_avwd, e_avwd);
      n_avw += int'(s_avw); n_avr += int'(s_avr); n_rdv += int'(s_rdv0) + int'(s_rdv1);
      @(posedge clk);
      req = {bus.m1_write | bus.m1_read, bus.m0_write | bus.m0_read};
      if (reset) begin
         age = 0; last_w = 1'b1;
      end else if (age == 0) begin
         if (req != 2'b00) begin
            owner  = (req == 2'b11) ? !last_w : req[1];
            last_w = owner;
            age    = 1;
         end
      end else if (age == 1) begin
         age = (!w && r) ? 2 : 0;
      end else begin
         age = 0;
      end
      #1;
      bus.avalon_readdata = $urandom;
   endtask

   initial begin
      reset = 1'b1;
      bus.avalon_readdata = '0;
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      cycle(); cycle();
      chk("rst_wait0", s_wait0, 1'b1);
      chk("rst_wait1", s_wait1, 1'b1);
      reset = 1'b0;
      cycle();

      // 1: single m0 write
      drive(1'b1, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, '0);
      cycle();
      chk("s1_wait0_T", s_wait0, 1'b1);
      cycle();
      chk("s1_avw", s_avw, 1'b1);
      chk("s1_avwd", s_avwd, 32'h0000_00A5);
      chk("s1_wait0_T1", s_wait0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      cycle();
      chk("s1_wait0_after", s_wait0, 1'b1);
      chk("s1_avw_after", s_avw, 1'b0);

      // 2: m1 read, slave returns a fixed word
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      cycle();
      cycle();
      chk("s2_avr", s_avr, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      bus.avalon_readdata = 32'h1234_5678;
      cycle();
      chk("s2_rdv1", s_rdv1, 1'b1);
      chk("s2_rd1", s_rd1, 32'h1234_5678);
      chk("s2_rdv0", s_rdv0, 1'b0);
      chk("s2_rd0", s_rd0, 32'h0);

      // 3: both masters write continuously after reset
      reset = 1'b1; cycle(); reset = 1'b0;
      grant_log.delete();
      drive(1'b1, 1'b0, 32'h1111_0000, 1'b1, 1'b0, 32'h2222_0000);
      for (int i = 0; i < 16; i++) cycle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("s3_transfers", grant_log.size(), 32'd8);
      begin
         int c0 = 0;
         for (int i = 0; i < grant_log.size(); i++) begin
            chk("s3_alternate", grant_log[i], i % 2);
            if (grant_log[i] == 0) c0++;
         end
         chk("s3_m0_count", c0, 32'd4);
      end
      cycle();

      // 4: m0 write and read together
      n_avw = 0; n_avr = 0; n_rdv = 0;
      drive(1'b1, 1'b1, 32'h0000_000F, 1'b0, 1'b0, '0);
      cycle(); cycle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      cycle(); cycle();
      chk("s4_avw_count", n_avw, 32'd1);
      chk("s4_avr_count", n_avr, 32'd0);
      chk("s4_rdv_count", n_rdv, 32'd0);

      // 5: reset during the data-return cycle
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      cycle(); cycle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      reset = 1'b1;
      cycle();
      chk("s5_rdv1_rst", s_rdv1, 1'b0);
      reset = 1'b0;
      cycle();
      chk("s5_rdv1_after", s_rdv1, 1'b0);
      chk("s5_wait0", s_wait0, 1'b1);
      chk("s5_wait1", s_wait1, 1'b1);
      chk("s5_avw", s_avw, 1'b0);
      chk("s5_avr", s_avr, 1'b0);

      // 6: m0 write dropped before ISSUE, then a tie goes to m1
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
      cycle();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      cycle();
      chk("s6_avw", s_avw, 1'b0);
      chk("s6_avr", s_avr, 1'b0);
      cycle();
      drive(1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0002);
      cycle(); cycle();
      chk("s6_tie_wait1", s_wait1, 1'b0);
      chk("s6_tie_wait0", s_wait0, 1'b1);
      chk("s6_tie_avwd", s_avwd, 32'h0000_0002);

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
         reset = ($urandom_range(63) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
